// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants and the operation class seen by the execute stage.
package riscv_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD     = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        OP_IMM  = 3'd0,
        OP      = 3'd1,
        LUI     = 3'd2,
        AUIPC   = 3'd3,
        ILLEGAL = 3'd4
    } op_class_t;

endpackage

// File: rtl/imm_gen.sv
// Combinational classifier: derives operation class, immediate and legality from one instruction word.
module imm_gen
    import riscv_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm,
    output op_class_t   op_class,
    output logic        illegal,
    output logic        rd_we
);

    logic [2:0] funct3;
    logic [6:0] funct7;

    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        op_class = ILLEGAL;
        imm      = '0;
        illegal  = 1'b0;
        case (instr[6:0])
            OPC_OP_IMM: begin
                op_class = OP_IMM;
                imm      = {{20{instr[31]}}, instr[31:20]};
                if ((funct3 == F3_SLL && funct7 != F7_ZERO) ||
                    (funct3 == F3_SRL_SRA && funct7 != F7_ZERO && funct7 != F7_ALT))
                    illegal = 1'b1;
            end
            OPC_OP:    op_class = OP;
            OPC_LUI: begin
                op_class = LUI;
                imm      = {instr[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                op_class = AUIPC;
                imm      = {instr[31:12], 12'b0};
            end
            default:   illegal = 1'b1;
        endcase
        // Illegal words carry no payload downstream.
        if (illegal) begin
            op_class = ILLEGAL;
            imm      = '0;
        end
    end

    assign rd_we = !illegal && (instr[11:7] != 5'd0);

endmodule

// File: rtl/decode_stage.sv
// Decode stage: register-file read with writeback bypass, operand selection, and the ID/EX pipeline register.
module decode_stage
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    output logic        id_ready,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        flush,
    output logic        ex_valid,
    input  logic        ex_ready,
    output logic [2:0]  ex_class,
    output logic [2:0]  ex_funct3,
    output logic        ex_bit_th,
    output logic [31:0] ex_in1,
    output logic [31:0] ex_in2,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rd,
    output logic        ex_rd_we,
    output logic        ex_illegal
);

    logic [31:0] imm;
    op_class_t   op_class;
    logic        illegal;
    logic        rd_we;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [2:0]  funct3;
    logic        accept;

    imm_gen u_imm_gen (
        .instr    (if_instr),
        .imm      (imm),
        .op_class (op_class),
        .illegal  (illegal),
        .rd_we    (rd_we)
    );

    assign rs1_addr = if_instr[19:15];
    assign rs2_addr = if_instr[24:20];

    // A same-cycle writeback wins over the stale register-file read; x0 is never forwarded.
    assign rs1_val = (wb_we && wb_rd != 5'd0 && wb_rd == rs1_addr) ? wb_data : rs1_data;
    assign rs2_val = (wb_we && wb_rd != 5'd0 && wb_rd == rs2_addr) ? wb_data : rs2_data;

    always_comb begin
        in1    = '0;
        in2    = '0;
        funct3 = F3_ADD;
        case (op_class)
            OP_IMM: begin
                in1    = rs1_val;
                funct3 = if_instr[14:12];
            end
            OP: begin
                in1    = rs1_val;
                in2    = rs2_val;
                funct3 = if_instr[14:12];
            end
            AUIPC:   in1 = if_pc;
            default: ;
        endcase
    end

    assign id_ready = !ex_valid || ex_ready;
    assign accept   = if_valid && id_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid   <= 1'b0;
            ex_class   <= '0;
            ex_funct3  <= '0;
            ex_bit_th  <= 1'b0;
            ex_in1     <= '0;
            ex_in2     <= '0;
            ex_imm     <= '0;
            ex_rd      <= '0;
            ex_rd_we   <= 1'b0;
            ex_illegal <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (accept) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            ex_valid   <= 1'b1;
            ex_class   <= op_class;
            ex_funct3  <= funct3;
            ex_bit_th  <= !illegal && !if_instr[30];
            ex_in1     <= in1;
            ex_in2     <= in2;
            ex_imm     <= imm;
            ex_rd      <= if_instr[11:7];
            ex_rd_we   <= rd_we;
            ex_illegal <= illegal;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

endmodule
